branch_resolve_unit: RTL and testbench

Branch execution stage of the out-of-order core. It sits between the branch reservation station (upstream) and the CDB/ROB result arbiter (downstream).
- Takes issued BR/JAL/JALR micro-ops with ready operands and evaluates the condition using the existing combinational comparator branch_alu.
- Computes the architectural next PC and link value.
- Detects mispredicts against the front-end prediction.
- Delivers one registered result per op over a valid/ready handshake.

---
 rtl/rv32i_types.sv | 32 +++
 rtl/branch_alu.sv | 35 +++
 rtl/branch_target_gen.sv | 28 ++
 rtl/branch_resolve_unit.sv | 165 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I execution types: branch kinds, branch comparison codes and the
// resolved-branch record handed to the CDB/ROB arbiter.
package rv32i_types;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BR_ROB_IDX_W = 4;

    typedef enum logic [1:0] {
        BK_BR   = 2'b00,
        BK_JAL  = 2'b01,
        BK_JALR = 2'b10
    } br_kind_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    typedef struct packed {
        logic [BR_ROB_IDX_W-1:0] rob_idx;
        logic                    taken;
        logic [XLEN-1:0]         next_pc;
        logic [XLEN-1:0]         link;
        logic                    mispredict;
        logic                    misaligned;
    } br_result_t;

endpackage

// File: rtl/branch_alu.sv
// Combinational branch comparator. Encodings outside the six legal branch
// funct3 values resolve to not-taken so nothing undefined leaks downstream.
module branch_alu
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    always_comb begin
        eq   = (rs1 == rs2);
        lt_s = ($signed(rs1) < $signed(rs2));
        lt_u = (rs1 < rs2);
    end

    always_comb begin
        taken = 1'b0;
        case (branch_funct3_t'(funct3))
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_target_gen.sv
// Target and link address generation for BR/JAL/JALR. All adds are 32-bit
// modulo; JALR clears bit 0 of the sum as the ISA requires.
module branch_target_gen
    import rv32i_types::*;
(
    input  logic [1:0]  kind,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    output logic [31:0] target,
    output logic [31:0] link
);

    logic [31:0] pc_rel;
    logic [31:0] reg_rel;

    always_comb begin
        pc_rel  = pc + imm;
        reg_rel = rs1 + imm;
        link    = pc + 32'd4;
        target  = pc_rel;
        case (br_kind_t'(kind))
            BK_JALR: target = reg_rel & ~32'h1;
            default: target = pc_rel;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch execution stage: two-stage valid/ready pipeline that resolves
// BR/JAL/JALR ops, flags mispredicts and counts delivered results.
module branch_resolve_unit
    import rv32i_types::*;
#(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [1:0]           iss_kind,
    input  logic [2:0]           iss_funct3,
    input  logic [31:0]          iss_pc,
    input  logic [31:0]          iss_rs1,
    input  logic [31:0]          iss_rs2,
    input  logic [31:0]          iss_imm,
    input  logic                 iss_pred_taken,
    input  logic [31:0]          iss_pred_target,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ROB_IDX_W-1:0] res_rob_idx,
    output logic                 res_taken,
    output logic [31:0]          res_next_pc,
    output logic [31:0]          res_link,
    output logic                 res_mispredict,
    output logic                 res_misaligned,
    output logic [CNT_W-1:0]     cnt_resolved,
    output logic [CNT_W-1:0]     cnt_mispredict
);

    typedef struct packed {
        br_kind_t             kind;
        logic [2:0]           funct3;
        logic [31:0]          pc;
        logic [31:0]          rs1;
        logic [31:0]          rs2;
        logic [31:0]          imm;
        logic                 pred_taken;
        logic [31:0]          pred_target;
        logic [ROB_IDX_W-1:0] rob_idx;
    } s1_op_t;

    logic             s1_valid_q;
    s1_op_t           s1_op_q;
    logic             s2_valid_q;
    br_result_t       s2_res_q;
    logic [CNT_W-1:0] cnt_resolved_q;
    logic [CNT_W-1:0] cnt_mispredict_q;

    logic       s2_free;
    logic       s1_adv;
    logic       iss_fire;
    logic       res_fire;
    logic       cond_taken;
    logic       taken;
    logic [31:0] target;
    logic [31:0] link;
    br_result_t res_d;

    // Ready depends only on pipeline state and res_ready, never on iss_valid.
    always_comb begin
        s2_free   = !s2_valid_q || res_ready;
        s1_adv    = s1_valid_q && s2_free;
        iss_ready = !s1_valid_q || s2_free;
        iss_fire  = iss_valid && iss_ready;
        res_fire  = s2_valid_q && res_ready && !flush;
    end

    branch_alu u_branch_alu (
        .funct3 (s1_op_q.funct3),
        .rs1    (s1_op_q.rs1),
        .rs2    (s1_op_q.rs2),
        .taken  (cond_taken)
    );

    branch_target_gen u_branch_target_gen (
        .kind   (s1_op_q.kind),
        .pc     (s1_op_q.pc),
        .rs1    (s1_op_q.rs1),
        .imm    (s1_op_q.imm),
        .target (target),
        .link   (link)
    );

    always_comb begin
        taken = 1'b0;
        case (s1_op_q.kind)
            BK_BR:           taken = cond_taken;
            BK_JAL, BK_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase

        res_d            = '0;
        // Tag width in the shared record is fixed by the package.
        res_d.rob_idx    = BR_ROB_IDX_W'(s1_op_q.rob_idx);
        res_d.taken      = taken;
        res_d.next_pc    = taken ? target : link;
        res_d.link       = link;
        res_d.mispredict = (taken != s1_op_q.pred_taken) ||
                           (taken && (target != s1_op_q.pred_target));
        res_d.misaligned = taken && target[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s2_res_q   <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= res_d;
                end
            end
            if (iss_fire) begin
                s1_valid_q          <= 1'b1;
                s1_op_q.kind        <= br_kind_t'(iss_kind);
                s1_op_q.funct3      <= iss_funct3;
                s1_op_q.pc          <= iss_pc;
                s1_op_q.rs1         <= iss_rs1;
                s1_op_q.rs2         <= iss_rs2;
                s1_op_q.imm         <= iss_imm;
                s1_op_q.pred_taken  <= iss_pred_taken;
                s1_op_q.pred_target <= iss_pred_target;
                s1_op_q.rob_idx     <= iss_rob_idx;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_resolved_q   <= '0;
            cnt_mispredict_q <= '0;
        end else if (res_fire) begin
            cnt_resolved_q <= cnt_resolved_q + CNT_W'(1);
            if (s2_res_q.mispredict) begin
                cnt_mispredict_q <= cnt_mispredict_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        res_valid      = s2_valid_q;
        res_rob_idx    = ROB_IDX_W'(s2_res_q.rob_idx);
        res_taken      = s2_res_q.taken;
        res_next_pc    = s2_res_q.next_pc;
        res_link       = s2_res_q.link;
        res_mispredict = s2_res_q.mispredict;
        res_misaligned = s2_res_q.misaligned;
        cnt_resolved   = cnt_resolved_q;
        cnt_mispredict = cnt_mispredict_q;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus a randomized run
// scored against an in-order reference queue.
module tb_branch_resolve_unit;
    import rv32i_types::*;

    localparam int unsigned RW = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, iss_valid, iss_ready;
    logic [1:0]    iss_kind;
    logic [2:0]    iss_funct3;
    logic [31:0]   iss_pc, iss_rs1, iss_rs2, iss_imm, iss_pred_target;
    logic          iss_pred_taken;
    logic [RW-1:0] iss_rob_idx;
    logic          res_valid, res_ready, res_taken, res_mispredict, res_misaligned;
    logic [RW-1:0] res_rob_idx;
    logic [31:0]   res_next_pc, res_link;
    logic [CW-1:0] cnt_resolved, cnt_mispredict;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ROB_IDX_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_kind(iss_kind),
        .iss_funct3(iss_funct3), .iss_pc(iss_pc), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_imm(iss_imm), .iss_pred_taken(iss_pred_taken),
        .iss_pred_target(iss_pred_target), .iss_rob_idx(iss_rob_idx),
        .res_valid(res_valid), .res_ready(res_ready), .res_rob_idx(res_rob_idx),
        .res_taken(res_taken), .res_next_pc(res_next_pc), .res_link(res_link),
        .res_mispredict(res_mispredict), .res_misaligned(res_misaligned),
        .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
    );

    typedef struct packed {
        logic [1:0]    kind;
        logic [2:0]    f3;
        logic [31:0]   pc, rs1, rs2, imm;
        logic          pt;
        logic [31:0]   ptgt;
        logic [RW-1:0] rob;
    } op_t;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic          taken;
        logic [31:0]   npc, link;
        logic          mis, mal;
    } res_t;

    int tests_run = 0;
    int tests_failed = 0;

    res_t          exp_q[$];
    logic [CW-1:0] exp_cnt_res, exp_cnt_mis;
    op_t           cur_op;
    logic          s_rfire, s_underflow;
    res_t          s_got, s_exp;

    // Architectural behaviour of a branch op, straight from the ISA rules.
    function automatic res_t ref_res(input op_t o);
        res_t r;
        logic tk;
        logic [31:0] tgt;
        tk  = 1'b0;
        tgt = o.pc + o.imm;
        case (o.kind)
            2'd0: case (o.f3)
                3'd0: tk = (o.rs1 == o.rs2);
                3'd1: tk = (o.rs1 != o.rs2);
                3'd4: tk = ($signed(o.rs1) < $signed(o.rs2));
                3'd5: tk = ($signed(o.rs1) >= $signed(o.rs2));
                3'd6: tk = (o.rs1 < o.rs2);
                3'd7: tk = (o.rs1 >= o.rs2);
                default: tk = 1'b0;
            endcase
            2'd1: tk = 1'b1;
            2'd2: begin tk = 1'b1; tgt = (o.rs1 + o.imm) & 32'hFFFF_FFFE; end
            default: tk = 1'b0;
        endcase
        r.rob   = o.rob;
        r.taken = tk;
        r.link  = o.pc + 32'd4;
        r.npc   = tk ? tgt : o.pc + 32'd4;
        r.mis   = (tk != o.pt) || (tk && tgt != o.ptgt);
        r.mal   = tk && tgt[1];
        return r;
    endfunction

    function automatic op_t mk(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptgt, input logic [RW-1:0] rob);
        op_t o;
        o.kind = k; o.f3 = f3; o.pc = pc; o.rs1 = a; o.rs2 = b; o.imm = imm;
        o.pt = pt; o.ptgt = ptgt; o.rob = rob;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        cur_op          = o;
        iss_valid       = 1'b1;
        iss_kind        = o.kind;
        iss_funct3      = o.f3;
        iss_pc          = o.pc;
        iss_rs1         = o.rs1;
        iss_rs2         = o.rs2;
        iss_imm         = o.imm;
        iss_pred_taken  = o.pt;
        iss_pred_target = o.ptgt;
        iss_rob_idx     = o.rob;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
    endtask

    // One clock: sample handshakes, advance, update the reference model.
    task automatic step();
        logic acc;
        res_t acc_res;
        #1;
        s_rfire     = 1'b0;
        s_underflow = 1'b0;
        if (!rst && !flush && res_valid && res_ready) begin
            s_rfire = 1'b1;
            s_got   = '{rob: res_rob_idx, taken: res_taken, npc: res_next_pc,
                        link: res_link, mis: res_mispredict, mal: res_misaligned};
            if (exp_q.size() == 0) s_underflow = 1'b1;
            else s_exp = exp_q.pop_front();
        end
        acc     = !rst && !flush && iss_valid && iss_ready;
        acc_res = ref_res(cur_op);
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
            if (rst) begin exp_cnt_res = '0; exp_cnt_mis = '0; end
        end else begin
            if (s_rfire) begin
                exp_cnt_res = exp_cnt_res + 1'b1;
                if (!s_underflow && s_exp.mis) exp_cnt_mis = exp_cnt_mis + 1'b1;
            end
            if (acc) exp_q.push_back(acc_res);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0; idle();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        tests_run++; if (iss_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_iss_ready: got %b want 1", iss_ready); end
        tests_run++; if (res_next_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_next_pc: got %h want 0", res_next_pc); end
        tests_run++; if (res_link !== 32'h0) begin tests_failed++; $display("FAIL reset_link: got %h want 0", res_link); end
        tests_run++; if (res_rob_idx !== '0) begin tests_failed++; $display("FAIL reset_rob_idx: got %h want 0", res_rob_idx); end
        tests_run++; if (cnt_resolved !== '0) begin tests_failed++; $display("FAIL reset_cnt_resolved: got %0d want 0", cnt_resolved); end
        tests_run++; if (cnt_mispredict !== '0) begin tests_failed++; $display("FAIL reset_cnt_mispredict: got %0d want 0", cnt_mispredict); end
    endtask

    task automatic test_beq();
        do_reset();
        res_ready = 1'b1;
        drive_op(mk(2'd0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 4'd3));
        step(); idle();
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL beq_latency_early: res_valid got %b want 0", res_valid); end
        step();
        tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL beq_latency: res_valid got %b want 1", res_valid); end
        tests_run++; if (res_taken !== 1'b1) begin tests_failed++; $display("FAIL beq_taken: got %b want 1", res_taken); end
        tests_run++; if (res_next_pc !== 32'h120) begin tests_failed++; $display("FAIL beq_next_pc: got %h want 120", res_next_pc); end
        tests_run++; if (res_mispredict !== 1'b0) begin tests_failed++; $display("FAIL beq_mispredict: got %b want 0", res_mispredict); end
        tests_run++; if (res_rob_idx !== 4'd3) begin tests_failed++; $display("FAIL beq_rob: got %h want 3", res_rob_idx); end
        step();
        tests_run++; if (cnt_resolved !== 4'd1) begin tests_failed++; $display("FAIL beq_cnt_resolved: got %0d want 1", cnt_resolved); end
    endtask

    task automatic test_blt_bltu();
        do_reset();
        res_ready = 1'b1;
        drive_op(mk(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0, 4'd1));
        step();
        drive_op(mk(2'd0, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0, 4'd2));
        step(); idle();
        tests_run++; if (res_taken !== 1'b1) begin tests_failed++; $display("FAIL blt_taken: got %b want 1", res_taken); end
        tests_run++; if (res_mispredict !== 1'b1) begin tests_failed++; $display("FAIL blt_mispredict: got %b want 1", res_mispredict); end
        tests_run++; if (res_next_pc !== 32'h210) begin tests_failed++; $display("FAIL blt_next_pc: got %h want 210", res_next_pc); end
        step();
        tests_run++; if (res_rob_idx !== 4'd2) begin tests_failed++; $display("FAIL bltu_rob: got %h want 2", res_rob_idx); end
        tests_run++; if (res_taken !== 1'b0) begin tests_failed++; $display("FAIL bltu_taken: got %b want 0", res_taken); end
        tests_run++; if (res_mispredict !== 1'b0) begin tests_failed++; $display("FAIL bltu_mispredict: got %b want 0", res_mispredict); end
        tests_run++; if (res_next_pc !== 32'h204) begin tests_failed++; $display("FAIL bltu_next_pc: got %h want 204", res_next_pc); end
        step();
        tests_run++; if (cnt_mispredict !== 4'd1) begin tests_failed++; $display("FAIL blt_cnt_mispredict: got %0d want 1", cnt_mispredict); end
        tests_run++; if (cnt_resolved !== 4'd2) begin tests_failed++; $display("FAIL blt_cnt_resolved: got %0d want 2", cnt_resolved); end
    endtask

    task automatic test_jalr();
        do_reset();
        res_ready = 1'b1;
        drive_op(mk(2'd2, 3'd0, 32'h40, 32'h2003, 32'h0, 32'h0, 1'b0, 32'h0, 4'd7));
        step(); idle(); step();
        tests_run++; if (res_taken !== 1'b1) begin tests_failed++; $display("FAIL jalr_taken: got %b want 1", res_taken); end
        tests_run++; if (res_next_pc !== 32'h2002) begin tests_failed++; $display("FAIL jalr_next_pc: got %h want 2002", res_next_pc); end
        tests_run++; if (res_link !== 32'h44) begin tests_failed++; $display("FAIL jalr_link: got %h want 44", res_link); end
        tests_run++; if (res_misaligned !== 1'b1) begin tests_failed++; $display("FAIL jalr_misaligned: got %b want 1", res_misaligned); end
        step();
    endtask

    task automatic test_back_pressure();
        do_reset();
        res_ready = 1'b0;
        drive_op(mk(2'd1, 3'd0, 32'h1000, 32'h0, 32'h0, 32'h8, 1'b1, 32'h1008, 4'd1));
        #1;
        tests_run++; if (iss_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_1: got %b want 1", iss_ready); end
        step();
        drive_op(mk(2'd1, 3'd0, 32'h2000, 32'h0, 32'h0, 32'h8, 1'b1, 32'h2008, 4'd2));
        #1;
        tests_run++; if (iss_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_2: got %b want 1", iss_ready); end
        step();
        drive_op(mk(2'd1, 3'd0, 32'h3000, 32'h0, 32'h0, 32'h8, 1'b1, 32'h3008, 4'd3));
        #1;
        tests_run++; if (iss_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_3: got %b want 0", iss_ready); end
        step();
        tests_run++; if (res_rob_idx !== 4'd1 || res_next_pc !== 32'h1008) begin tests_failed++; $display("FAIL bp_head: got rob %h pc %h want 1/1008", res_rob_idx, res_next_pc); end
        step();
        tests_run++; if (res_valid !== 1'b1 || res_rob_idx !== 4'd1 || res_next_pc !== 32'h1008 || res_link !== 32'h1004)
            begin tests_failed++; $display("FAIL bp_stable: got v %b rob %h pc %h link %h want 1/1/1008/1004", res_valid, res_rob_idx, res_next_pc, res_link); end
        res_ready = 1'b1;
        #1;
        tests_run++; if (iss_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_release: got %b want 1", iss_ready); end
        step(); idle();
        tests_run++; if (res_rob_idx !== 4'd2 || res_next_pc !== 32'h2008) begin tests_failed++; $display("FAIL bp_second: got rob %h pc %h want 2/2008", res_rob_idx, res_next_pc); end
        step();
        tests_run++; if (res_rob_idx !== 4'd3 || res_next_pc !== 32'h3008) begin tests_failed++; $display("FAIL bp_third: got rob %h pc %h want 3/3008", res_rob_idx, res_next_pc); end
        step();
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: res_valid got %b want 0", res_valid); end
        tests_run++; if (cnt_resolved !== 4'd3) begin tests_failed++; $display("FAIL bp_cnt: got %0d want 3", cnt_resolved); end
    endtask

    task automatic test_flush();
        do_reset();
        res_ready = 1'b0;
        drive_op(mk(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0, 4'd1));
        step();
        drive_op(mk(2'd1, 3'd0, 32'h600, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0, 4'd2));
        step();
        flush = 1'b1; res_ready = 1'b1;
        drive_op(mk(2'd1, 3'd0, 32'h700, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0, 4'd3));
        step();
        flush = 1'b0; idle();
        #1;
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_res_valid: got %b want 0", res_valid); end
        tests_run++; if (cnt_resolved !== 4'd0) begin tests_failed++; $display("FAIL flush_cnt_resolved: got %0d want 0", cnt_resolved); end
        tests_run++; if (cnt_mispredict !== 4'd0) begin tests_failed++; $display("FAIL flush_cnt_mispredict: got %0d want 0", cnt_mispredict); end
        tests_run++; if (iss_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_iss_ready: got %b want 1", iss_ready); end
        step();
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_dropped_op: res_valid got %b want 0", res_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        res_ready = 1'b1;
        drive_op(mk(2'd0, 3'd1, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0, 4'd5));
        step(); idle(); step();
        tests_run++; if (res_taken !== 1'b0) begin tests_failed++; $display("FAIL wrap_taken: got %b want 0", res_taken); end
        tests_run++; if (res_next_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_next_pc: got %h want 0", res_next_pc); end
        tests_run++; if (res_link !== 32'h0) begin tests_failed++; $display("FAIL wrap_link: got %h want 0", res_link); end
        step();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_op(mk(2'd1, 3'd0, 32'h100 * i, 32'h0, 32'h0, 32'h10, 1'b1, 32'h100 * i + 32'h10, 4'(i)));
            step();
        end
        idle();
        tests_run++; if (cnt_resolved !== 4'd14) begin tests_failed++; $display("FAIL wrap_cnt_mid: got %0d want 14", cnt_resolved); end
        step(); step();
        tests_run++; if (cnt_resolved !== 4'd0) begin tests_failed++; $display("FAIL wrap_cnt_16: got %0d want 0", cnt_resolved); end
        tests_run++; if (cnt_mispredict !== 4'd0) begin tests_failed++; $display("FAIL wrap_cnt_mis: got %0d want 0", cnt_mispredict); end
    endtask

    function automatic op_t rand_op();
        op_t o;
        res_t r;
        int unsigned k;
        k      = $urandom_range(0, 9);
        o.kind = (k < 6) ? 2'd0 : (k < 8) ? 2'd1 : 2'd2;
        o.f3   = 3'($urandom_range(0, 7));
        o.rs1  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        o.rs2  = ($urandom_range(0, 3) == 0) ? o.rs1 : (($urandom_range(0, 1) == 0) ?
                 32'($urandom_range(0, 15)) : $urandom);
        o.pc   = $urandom & 32'hFFFF_FFFC;
        o.imm  = ($urandom_range(0, 1) == 0) ? {{20{o.rs1[11]}}, 12'($urandom)} : $urandom;
        o.pt   = 1'($urandom_range(0, 1));
        o.ptgt = $urandom;
        o.rob  = 4'($urandom);
        r = ref_res(o);
        if ($urandom_range(0, 1) == 0) o.ptgt = r.npc;
        return o;
    endfunction

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0) drive_op(rand_op());
            else idle();
            res_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            step();
            if (s_rfire) begin
                tests_run++;
                if (s_underflow) begin
                    tests_failed++;
                    $display("FAIL rand_unexpected_result: got rob %h want no result", s_got.rob);
                end else if (s_got !== s_exp) begin
                    tests_failed++;
                    $display("FAIL rand_result: got %h want %h", s_got, s_exp);
                end
            end
            tests_run++;
            if (cnt_resolved !== exp_cnt_res || cnt_mispredict !== exp_cnt_mis) begin
                tests_failed++;
                $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", cnt_resolved, cnt_mispredict,
                         exp_cnt_res, exp_cnt_mis);
            end
        end
        flush = 1'b0; idle(); res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (s_rfire) begin
                tests_run++;
                if (s_underflow || s_got !== s_exp) begin
                    tests_failed++;
                    $display("FAIL rand_drain: got %h want %h", s_got, s_exp);
                end
            end
        end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_drained: res_valid got %b want 0", res_valid); end
        tests_run++; if (cnt_resolved !== exp_cnt_res) begin tests_failed++; $display("FAIL rand_final_cnt: got %0d want %0d", cnt_resolved, exp_cnt_res); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        exp_cnt_res = '0; exp_cnt_mis = '0;
        drive_op(mk(2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0));
        idle();
        test_reset();
        test_beq();
        test_blt_bltu();
        test_jalr();
        test_back_pressure();
        test_flush();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
